// File: rtl/dcache_reader.sv
// Burst reader: walks a Dcache read port from a base address and streams the
// words out through a single registered valid/ready output stage.
module dcache_reader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state_o
);

  // Handshake: a word transfers on a posedge where m_valid && m_ready. Once
  // m_valid is high, m_data/m_last stay frozen until that transfer happens.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(512);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [LEN_W-1:0]  len_clamped;
  logic              load;

  assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = len_clamped;
          state_d = (len_clamped != '0) ? S_STREAM : S_DONE;
        end
      end
      S_STREAM: begin
        // The output register refills whenever it is empty or being drained.
        load = (rem_q != '0) && (!m_valid_q || m_ready);
        if (load) begin
          m_data_d  = rd_data;
          m_valid_d = 1'b1;
          m_last_d  = (rem_q == LEN_W'(1));
          addr_d    = addr_q + ADDR_W'(1);
          rem_d     = rem_q - LEN_W'(1);
        end else if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end
        if (m_valid_q && m_ready && m_last_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end

  // busy also covers the cycle in which the start is being accepted.
  assign busy        = (state_q != S_IDLE) || (state_q == S_IDLE && start && rst_n);
  assign done        = (state_q == S_DONE);
  assign rd_en       = (state_q == S_STREAM) && (rem_q != '0);
  assign rd_addr     = addr_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign m_data      = m_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dcache_reader.sv
// Randomized bench for dcache_reader: a behavioural Dcache array, a word-list
// reference model per burst, and a negedge scoreboard on the output stream.
module tb_dcache_reader;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 10;
  localparam int DEPTH  = 512;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_ready;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W:0]   exp_q[$];   // {last, data}

  int n_checks = 0;
  int n_pass   = 0;
  int accepted = 0;
  int done_seen = 0;
  int ready_pat[5] = '{1, 0, 0, 1, 1};

  logic              stall_prev = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;

  dcache_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .done(done), .dbg_state_o(dbg_state)
  );

  assign rd_data = mem[rd_addr];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("last_implies_valid", {63'd0, m_last & ~m_valid}, 64'd0);
      if (stall_prev) begin
        check("stall_valid_hold", {63'd0, m_valid}, 64'd1);
        check("stall_data_hold", {32'd0, m_data}, {32'd0, prev_data});
        check("stall_last_hold", {63'd0, m_last}, {63'd0, prev_last});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {32'd0, m_data}, 64'hdead_0000_0000);
        end else begin
          logic [DATA_W:0] e;
          e = exp_q.pop_front();
          check("word_data", {32'd0, m_data}, {32'd0, e[DATA_W-1:0]});
          check("word_last", {63'd0, m_last}, {63'd0, e[DATA_W]});
        end
        accepted++;
      end
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (done) done_seen++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  function automatic logic next_ready(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 3) != 0);
      default: return (k < 5) ? logic'(ready_pat[k] != 0) : 1'b1;
    endcase
  endfunction

  // Reference: a burst is the list of min(len,512) words starting at base,
  // addresses wrapping modulo the memory depth, with last on the final one.
  task automatic expect_burst(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({logic'(i == n - 1), mem[(base + i) % DEPTH]});
    end
  endtask

  // driver: one complete burst, mode 0=ready high, 1=random, 2=pattern
  task automatic run_burst(input int base, input int len, input int mode, input bit inject);
    int n, k, done_k, busy_cnt, d0;
    n = (len > 512) ? 512 : len;
    expect_burst(base, n);
    d0 = done_seen;
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = ADDR_W'(base);
    length    = LEN_W'(len);
    m_ready   = next_ready(mode, 0);
    @(negedge clk);
    check("busy_at_start", {63'd0, busy}, 64'd1);
    busy_cnt = 1;
    k = 0;
    done_k = -1;
    while (done_k < 0 && k < 4000) begin
      @(posedge clk); #1;
      k++;
      start = inject && (k == 3);
      if (start) begin
        base_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        length    = LEN_W'($urandom_range(1, 20));
      end
      m_ready = next_ready(mode, k);
      @(negedge clk);
      if (busy) busy_cnt++;
      if (k == 1) check("no_early_valid", {63'd0, m_valid}, 64'd0);
      if (k == 2 && n > 0) check("first_word_latency", {63'd0, m_valid}, 64'd1);
      if (done) done_k = k;
    end
    if (done_k < 0) check("timeout_waiting_done", 64'd1, 64'd0);
    if (mode == 0) check("done_cycle", 64'(done_k), 64'((n == 0) ? 1 : n + 2));
    check("busy_span", 64'(busy_cnt), 64'(done_k + 1));
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("done_single_cycle", {63'd0, done}, 64'd0);
    check("idle_not_busy", {63'd0, busy}, 64'd0);
    check("all_words_seen", 64'(exp_q.size()), 64'd0);
    check("one_done_pulse", 64'(done_seen - d0), 64'd1);
    exp_q.delete();
  endtask

  initial begin
    int acc0, d0, wait_cnt;
    for (int k = 0; k < DEPTH; k++) mem[k] = DATA_W'(k + 32'h100);
    rst_n = 1'b0; start = 1'b1; base_addr = 9'd77; length = 10'd5; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_m_last", {63'd0, m_last}, 64'd0);
    check("rst_m_data", {32'd0, m_data}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_rd_en", {63'd0, rd_en}, 64'd0);
    check("rst_rd_addr", {55'd0, rd_addr}, 64'd0);

    run_burst(0, 4, 0, 1'b0);
    run_burst(510, 4, 0, 1'b0);
    run_burst(100, 3, 2, 1'b0);
    run_burst(42, 0, 0, 1'b0);
    run_burst(200, 6, 0, 1'b1);
    run_burst(300, 700, 0, 1'b0);

    // reset after the second word of an 8-word burst
    expect_burst(0, 8);
    acc0 = accepted;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 9'd0; length = 10'd8; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_cnt = 0;
    while (accepted < acc0 + 2 && wait_cnt < 100) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check("reset_test_words", 64'(accepted - acc0), 64'd2);
    rst_n = 1'b0;
    d0 = done_seen;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_m_valid", {63'd0, m_valid}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_rd_addr", {55'd0, rd_addr}, 64'd0);
    repeat (3) @(negedge clk);
    check("midrst_no_done", 64'(done_seen - d0), 64'd0);
    run_burst(5, 1, 0, 1'b0);

    // randomized bursts over randomized memory contents
    for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
    for (int t = 0; t < 16; t++) begin
      int b, l, m;
      b = $urandom_range(0, DEPTH - 1);
      l = ($urandom_range(0, 7) == 0) ? $urandom_range(500, 1023) : $urandom_range(0, 24);
      m = $urandom_range(0, 1);
      run_burst(b, l, m, (l >= 2) && ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
